// File: rtl/pipe_pkg.sv
// Shared types and defaults for the two-entry skid pipeline stage.
package pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_en_reg.sv
// Width-parametrised register with load enable and synchronous clear.
module pipe_en_reg #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // storage: clear on reset, load on enable, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {W{1'b0}};
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry (main + skid) pipeline stage with valid/ready handshakes,
// flush bubble insertion and control gating on empty output.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = DATA_W + CTRL_W;

  pipe_state_e        state_r;
  pipe_state_e        state_nxt_s;
  logic               accept_s;
  logic               emit_s;
  logic               main_en_s;
  logic               skid_en_s;
  logic               main_sel_skid_s;
  logic [ENTRY_W-1:0] in_entry_s;
  logic [ENTRY_W-1:0] main_d_s;
  logic [ENTRY_W-1:0] main_q_s;
  logic [ENTRY_W-1:0] skid_q_s;

  // Handshake signals depend only on registered state (and reset), never on out_ready.
  assign in_ready  = (state_r != FULL) && !reset;
  assign out_valid = (state_r != EMPTY);
  assign occupancy = occ_of(state_r);
  assign accept_s  = in_valid && in_ready;
  assign emit_s    = out_valid && out_ready;

  assign in_entry_s = {in_ctrl, in_data};
  assign main_d_s   = main_sel_skid_s ? skid_q_s : in_entry_s;

  // A bubble must never carry write enables downstream.
  assign out_data = main_q_s[DATA_W-1:0];
  assign out_ctrl = out_valid ? main_q_s[ENTRY_W-1:DATA_W] : {CTRL_W{1'b0}};

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and register load selection; flush overrides any handshake
  always_comb begin
    state_nxt_s     = state_r;
    main_en_s       = 1'b0;
    skid_en_s       = 1'b0;
    main_sel_skid_s = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ONE;
            main_en_s   = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          case ({accept_s, emit_s})
            2'b11: begin
              state_nxt_s = ONE;
              main_en_s   = 1'b1;
            end
            2'b10: begin
              state_nxt_s = FULL;
              skid_en_s   = 1'b1;
            end
            2'b01: begin
              state_nxt_s = EMPTY;
            end
            default: begin
              state_nxt_s = ONE;
            end
          endcase
        end
        FULL: begin
          if (emit_s) begin
            state_nxt_s     = ONE;
            main_en_s       = 1'b1;
            main_sel_skid_s = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  pipe_en_reg #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  pipe_en_reg #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en_s),
    .d     (in_entry_s),
    .q     (skid_q_s)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: directed scenarios plus a long random run.
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [8:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [8:0]  out_ctrl;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  c;
  } ent_t;

  ent_t        sb_q[$];
  int          chk_cnt    = 0;
  int          pass_cnt   = 0;
  int          model_cnt  = 0;
  int          acc_tot    = 0;
  int          emit_tot   = 0;
  int          drop_tot   = 0;
  bit          armed      = 1'b0;
  logic [15:0] last_front = 16'h0000;

  pipe_stage #(.DATA_W(16), .CTRL_W(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic [8:0] c, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every emission pop the scoreboard and compare
  always @(negedge clk) begin
    if (armed && !reset) begin
      if (out_valid) begin
        chk_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_front: out_valid=1 with no expected entry at %0t", $time);
        end else begin
          pass_cnt++;
          check("out_data", 32'(out_data), 32'(sb_q[0].d));
          check("out_ctrl", 32'(out_ctrl), 32'(sb_q[0].c));
          last_front = sb_q[0].d;
          if (out_ready && !flush) begin
            void'(sb_q.pop_front());
            emit_tot++;
          end
        end
      end else begin
        check("idle_data", 32'(out_data), 32'(last_front));
      end
    end
  end

  // Issue-side model: tracks occupancy, checks handshakes, pushes accepted entries
  always @(negedge clk) begin
    bit acc;
    bit emi;
    #1;
    if (reset) begin
      check("in_ready_reset", 32'(in_ready), 32'(0));
      drop_tot  += sb_q.size();
      sb_q.delete();
      model_cnt  = 0;
      last_front = 16'h0000;
      armed      = 1'b1;
    end else if (armed) begin
      check("in_ready", 32'(in_ready), 32'(model_cnt < 2));
      check("out_valid", 32'(out_valid), 32'(model_cnt != 0));
      check("occupancy", 32'(occupancy), 32'(model_cnt));
      if (model_cnt == 0) check("bubble_ctrl", 32'(out_ctrl), 32'(0));
      acc = in_valid && (model_cnt < 2);
      emi = (model_cnt != 0) && out_ready;
      if (flush) begin
        drop_tot += sb_q.size();
        sb_q.delete();
        model_cnt = 0;
      end else begin
        if (emi) model_cnt--;
        if (acc) begin
          sb_q.push_back('{d: in_data, c: in_ctrl});
          acc_tot++;
          model_cnt++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    cyc(1'b1, 16'hFFFF, 9'h1FF, 1'b0);
    cyc(1'b1, 16'hFFFF, 9'h1FF, 1'b0);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_occupancy", 32'(occupancy), 32'(0));
    check("rst_out_ctrl", 32'(out_ctrl), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // streaming at one entry per cycle
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 16'(i), 9'(9'h010 + i), 1'b1);
      check("stream_valid", 32'(out_valid), 32'(1));
      check("stream_data", 32'(out_data), 32'(i));
      check("stream_occ", 32'(occupancy), 32'(1));
    end
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    check("stream_drain_occ", 32'(occupancy), 32'(0));

    // back-pressure fills the skid entry
    cyc(1'b1, 16'hAAAA, 9'h0AA, 1'b0);
    cyc(1'b1, 16'hBBBB, 9'h0BB, 1'b0);
    check("bp_occ", 32'(occupancy), 32'(2));
    check("bp_in_ready", 32'(in_ready), 32'(0));
    check("bp_data", 32'(out_data), 32'(16'hAAAA));
    cyc(1'b1, 16'hCCCC, 9'h0CC, 1'b0);
    check("bp_hold_data", 32'(out_data), 32'(16'hAAAA));
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    check("bp_second", 32'(out_data), 32'(16'hBBBB));
    check("bp_in_ready_after", 32'(in_ready), 32'(1));
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    check("bp_empty_keeps", 32'(out_data), 32'(16'hBBBB));

    // bubble gating of control
    cyc(1'b1, 16'hC0DE, 9'h1FF, 1'b0);
    check("gate_ctrl_valid", 32'(out_ctrl), 32'(9'h1FF));
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    check("gate_ctrl_bubble", 32'(out_ctrl), 32'(0));
    check("gate_valid_low", 32'(out_valid), 32'(0));

    // flush while full
    cyc(1'b1, 16'h1111, 9'h011, 1'b0);
    cyc(1'b1, 16'h2222, 9'h022, 1'b0);
    check("fl_full", 32'(occupancy), 32'(2));
    flush = 1'b1;
    cyc(1'b1, 16'h3333, 9'h1FF, 1'b0);
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'(0));
    check("fl_ctrl", 32'(out_ctrl), 32'(0));
    check("fl_occ", 32'(occupancy), 32'(0));
    check("fl_data_kept", 32'(out_data), 32'(16'h1111));
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    check("fl_no_emerge", 32'(out_valid), 32'(0));

    // flush in ONE discards the same-cycle accept
    cyc(1'b1, 16'h5555, 9'h055, 1'b0);
    flush = 1'b1;
    cyc(1'b1, 16'h4444, 9'h044, 1'b0);
    flush = 1'b0;
    check("fl1_occ", 32'(occupancy), 32'(0));
    check("fl1_data", 32'(out_data), 32'(16'h5555));

    // reset mid-flight
    cyc(1'b1, 16'h7777, 9'h077, 1'b0);
    cyc(1'b1, 16'h8888, 9'h088, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    reset = 1'b0;
    check("mr_valid", 32'(out_valid), 32'(0));
    check("mr_occ", 32'(occupancy), 32'(0));
    check("mr_data", 32'(out_data), 32'(0));
    cyc(1'b1, 16'h1234, 9'h034, 1'b0);
    check("mr_first_valid", 32'(out_valid), 32'(1));
    check("mr_first_data", 32'(out_data), 32'(16'h1234));
    cyc(1'b0, 16'h0000, 9'h000, 1'b1);

    // random traffic with rare flushes
    for (int n = 0; n < 10000; n++) begin
      flush = ($urandom_range(0, 99) == 0);
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 9'($urandom),
          1'($urandom_range(0, 3) != 0));
    end
    flush = 1'b0;
    for (int n = 0; n < 4; n++) cyc(1'b0, 16'h0000, 9'h000, 1'b1);
    check("final_sb_empty", 32'(sb_q.size()), 32'(0));
    check("final_count", 32'(emit_tot + drop_tot), 32'(acc_tot));
    check("final_occ", 32'(occupancy), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
